// File: rtl/cla_nibble_sequencer.sv
// W-bit add/subtract sequencer driving an external 4-bit carry-lookahead adder
// one nibble per clock, with valid/ready handshakes on operands and result.
module cla_nibble_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic [3:0]   cla_a,
  output logic [3:0]   cla_b,
  output logic         cla_mode,
  output logic         cla_cin,
  input  logic [3:0]   cla_sum,
  input  logic         cla_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  localparam int NIB  = W / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            overflow_q, overflow_d;
  logic            zero_q, zero_d;
  logic            negative_q, negative_d;

  logic [3:0]      a_nib [NIB];
  logic [3:0]      b_nib [NIB];
  logic [W-1:0]    result_merged;
  logic            last_nib;

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  assign last_nib = (idx_q == LAST_IDX);

  // Result with the adder's current nibble dropped into slot idx.
  always_comb begin
    result_merged = result_q;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        result_merged[4*i +: 4] = cla_sum;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    cy_d       = cy_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    cla_a      = 4'd0;
    cla_b      = 4'd0;
    cla_mode   = 1'b0;
    cla_cin    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          idx_d   = '0;
          cy_d    = op_sub;
          state_d = RUN;
        end
      end

      RUN: begin
        cla_a    = a_nib[idx_q];
        cla_b    = b_nib[idx_q];
        cla_mode = sub_q;
        cla_cin  = cy_q;
        result_d = result_merged;
        cy_d     = cla_cout;
        idx_d    = idx_q + 1'b1;
        if (last_nib) begin
          // B's sign is taken post-inversion so one rule covers add and subtract.
          idx_d      = '0;
          state_d    = DONE;
          carry_d    = cla_cout;
          overflow_d = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (cla_sum[3] != a_q[W-1]);
          zero_d     = (result_merged == '0);
          negative_d = cla_sum[3];
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      cy_q       <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      cy_q       <= cy_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench: behavioural 4-bit adder on the cla_* ports, directed
// corner cases, backpressure, async abort and 1000 random back-to-back ops.
module tb_cla_nibble_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic [3:0]   cla_a, cla_b, cla_sum;
  logic         cla_mode, cla_cin, cla_cout;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, overflow, zero, negative;
  logic [4:0]   add_full;

  cla_nibble_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .cla_a(cla_a), .cla_b(cla_b), .cla_mode(cla_mode), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry(carry), .overflow(overflow),
    .zero(zero), .negative(negative)
  );

  // The 4-bit adder/subtractor: inverts B itself in subtract mode.
  assign add_full = {1'b0, cla_a} + {1'b0, (cla_mode ? ~cla_b : cla_b)} + {4'd0, cla_cin};
  assign cla_sum  = add_full[3:0];
  assign cla_cout = add_full[4];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic c, input logic o, input logic z,
                                       input logic n, input logic [15:0] r);
    return {12'd0, c, o, z, n, r};
  endfunction

  // Reference: plain integer arithmetic on the whole words.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sa, sb, sr;
    logic [16:0] u;
    logic c, o;
    sa = $signed(a);
    sb = $signed(b);
    sr = s ? (sa - sb) : (sa + sb);
    o  = (sr > 32767) || (sr < -32768);
    if (s) begin
      u = {1'b0, a} - {1'b0, b};
      c = (a >= b);
    end else begin
      u = {1'b0, a} + {1'b0, b};
      c = u[16];
    end
    return pack(c, o, (u[15:0] == 16'd0), u[15], u[15:0]);
  endfunction

  function automatic logic [31:0] dut_out();
    return pack(carry, overflow, zero, negative, result);
  endfunction

  logic [3:0] cin_seq, mode_seq;
  int lat;

  // Leaves the DUT in DONE with the result presented.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; cin_seq = '0; mode_seq = '0;
    while (!res_valid && lat < 20) begin
      if (lat < 4) begin
        cin_seq[lat]  = cla_cin;
        mode_seq[lat] = cla_mode;
      end
      @(posedge clk); #1; lat++;
    end
    check("res_valid_seen", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic finish_op();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  logic [15:0] da [6] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h0003, 16'h8000};
  logic [15:0] db [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h0001};
  logic        ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] dexp [6];

  initial begin
    logic [31:0] exp_v;
    logic [15:0] ra, rb;
    logic        rs;
    int          acc, prev, n;

    dexp[0] = pack(1'b0, 1'b0, 1'b0, 1'b0, 16'h2233);
    dexp[1] = pack(1'b0, 1'b1, 1'b0, 1'b1, 16'h8000);
    dexp[2] = pack(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    dexp[3] = pack(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    dexp[4] = pack(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE);
    dexp[5] = pack(1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", dut_out(), 32'd0);
    check("reset_hs", {30'd0, in_ready, res_valid}, 32'd2);
    check("reset_cla", {22'd0, cla_a, cla_b, cla_mode, cla_cin}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      start_op(da[i], db[i], ds[i]);
      check($sformatf("dir%0d_latency", i), lat, 32'd4);
      check($sformatf("dir%0d_result", i), dut_out(), dexp[i]);
      check($sformatf("dir%0d_model", i), dut_out(), model(da[i], db[i], ds[i]));
      check($sformatf("dir%0d_mode", i), {28'd0, mode_seq}, ds[i] ? 32'hF : 32'h0);
      if (i == 0) check("dir0_cin_seq", {28'd0, cin_seq}, 32'b1110);
      if (i == 3) check("dir3_first_cin", {31'd0, cin_seq[0]}, 32'd1);
      finish_op();
      check($sformatf("dir%0d_idle", i), {30'd0, in_ready, res_valid}, 32'd2);
    end

    // Backpressure: result holds, in_valid/op_a wiggling is ignored.
    start_op(16'h1234, 16'h5678, 1'b0);
    exp_v = model(16'h1234, 16'h5678, 1'b0);
    for (int k = 0; k < 10; k++) begin
      op_a = 16'($urandom);
      in_valid = k[0];
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), dut_out(), exp_v);
      check($sformatf("bp_hs%0d", k), {30'd0, in_ready, res_valid}, 32'd1);
    end
    in_valid = 1'b0;
    finish_op();
    check("bp_release_hs", {30'd0, in_ready, res_valid}, 32'd2);
    check("bp_idle_keep", dut_out(), exp_v);
    @(posedge clk); #1;
    check("bp_idle_stay", {30'd0, in_ready, res_valid}, 32'd2);

    // Asynchronous abort after two nibbles.
    op_a = 16'h1234; op_b = 16'h0FFF; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", dut_out(), 32'd0);
    check("abort_hs", {30'd0, in_ready, res_valid}, 32'd2);
    check("abort_cla", {22'd0, cla_a, cla_b, cla_mode, cla_cin}, 32'd0);
    @(posedge clk); #1;
    check("abort_no_valid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1;
    start_op(16'h00FF, 16'h0001, 1'b0);
    check("post_abort_result", dut_out(), pack(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100));
    finish_op();

    // Back-to-back random traffic with both handshakes held high.
    in_valid = 1'b1;
    res_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) begin
        ra = 16'h8000 ^ 16'(i);
        rb = (i % 100 == 0) ? ra : 16'hFFFF;
      end
      op_a = ra; op_b = rb; op_sub = rs;
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) check($sformatf("b2b%0d_interval", i), acc - prev, 32'd6);
      prev = acc;
      op_a = 16'($urandom); op_b = 16'($urandom); op_sub = 1'($urandom);
      n = 0;
      while (!res_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check($sformatf("b2b%0d_latency", i), n, 32'd4);
      check($sformatf("b2b%0d_result a=%h b=%h s=%0d", i, ra, rb, rs), dut_out(), model(ra, rb, rs));
      @(posedge clk); #1;
      check($sformatf("b2b%0d_idle", i), {30'd0, in_ready, res_valid}, 32'd2);
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
